// File: rtl/priority_irq_controller.sv
// priority_irq_controller
//   Catches rising edges on 4 request lines as sticky pending bits. It issues one
//   interrupt at a time for the highest unmasked pending source (index 3 is highest).
//   The consumer completes each service with ack. If no ack arrives, the service is
//   retired after ACK_TIMEOUT cycles and a sticky error flag is set.
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req_in[3:0]  request lines; a rising edge is one event
//   mask[3:0]    1 = source masked (kept pending, never selected)
//   ack          consumer acknowledge
//   err_clr      clears timeout_err
//   irq          interrupt valid (registered)
//   irq_id[1:0]  source being serviced, valid while irq=1 (registered)
//   pending[3:0] sticky pending bits (registered)
//   timeout_err  sticky timeout flag (registered)
module priority_irq_controller #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    input  logic       ack,
    input  logic       err_clr,
    output logic       irq,
    output logic [1:0] irq_id,
    output logic [3:0] pending,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;
    logic [1:0]       irq_id_q, irq_id_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       req_prev_q, req_prev_d;
    logic             timeout_err_q, timeout_err_d;

    logic [3:0]       rise;
    logic [3:0]       eligible;
    logic [1:0]       select;
    logic [3:0]       retire_vec;

    // Edge detect and highest-index priority select over unmasked pending sources
    always_comb begin
        rise       = req_in & ~req_prev_q;
        req_prev_d = req_in;
        eligible   = pending_q & ~mask;
        select     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (eligible[i]) begin
                select = 2'(i);
            end
        end
    end

    // Next-state and output logic for the service handshake
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        irq_d         = irq_q;
        irq_id_d      = irq_id_q;
        retire_vec    = 4'b0000;
        timeout_err_d = timeout_err_q;

        if (err_clr) begin
            timeout_err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (eligible != 4'b0000) begin
                    irq_id_d = select;
                    irq_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // ack takes precedence over a simultaneous timeout
                if (ack) begin
                    retire_vec[irq_id_q] = 1'b1;
                    irq_d                = 1'b0;
                    state_d              = ST_GAP;
                end else if (cnt_q == CNT_LAST) begin
                    retire_vec[irq_id_q] = 1'b1;
                    irq_d                = 1'b0;
                    timeout_err_d        = 1'b1;
                    state_d              = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // A new rising edge wins over retirement of the same source
        pending_d = (pending_q & ~retire_vec) | rise;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            irq_q         <= 1'b0;
            irq_id_q      <= 2'd0;
            pending_q     <= 4'b0000;
            req_prev_q    <= 4'b0000;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            irq_q         <= irq_d;
            irq_id_q      <= irq_id_d;
            pending_q     <= pending_d;
            req_prev_q    <= req_prev_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign irq         = irq_q;
    assign irq_id      = irq_id_q;
    assign pending     = pending_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_priority_irq_controller.sv
// Testbench for priority_irq_controller: directed scenarios followed by random
// traffic. Each cycle is compared against a behavioural reference model.
module tb_priority_irq_controller;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       ack;
    logic       err_clr;
    logic       irq;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [3:0] m_prev, m_pend;
    bit         m_irq, m_gap, m_err;
    int         m_id, m_age;

    priority_irq_controller #(.ACK_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .mask       (mask),
        .ack        (ack),
        .err_clr    (err_clr),
        .irq        (irq),
        .irq_id     (irq_id),
        .pending    (pending),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_edge();
        logic [3:0] rise, np, elig;
        if (!rst_n) begin
            m_prev = 4'h0; m_pend = 4'h0; m_irq = 0; m_gap = 0;
            m_err  = 0;    m_id   = 0;    m_age = 0;
            return;
        end
        rise   = req_in & ~m_prev;
        m_prev = req_in;
        np     = m_pend;
        elig   = m_pend & ~mask;
        if (err_clr) m_err = 0;
        if (m_irq) begin
            if (ack || m_age == int'(TO) - 1) begin
                np[m_id] = 1'b0;
                if (!ack) m_err = 1;
                m_irq = 0;
                m_gap = 1;
            end else begin
                m_age++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (elig != 4'h0) begin
            for (int i = 3; i >= 0; i--) begin
                if (elig[i]) begin
                    m_id = i;
                    break;
                end
            end
            m_irq = 1;
            m_age = 0;
        end
        m_pend = np | rise;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("irq", 8'(irq), 8'(m_irq));
        if (m_irq) chk("irq_id", 8'(irq_id), 8'(m_id));
        chk("pending", 8'(pending), 8'(m_pend));
        chk("timeout_err", 8'(timeout_err), 8'(m_err));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_in = 4'hF; mask = 4'h0; ack = 1'b0; err_clr = 1'b0;

        // 1: reset with requests held high
        repeat (3) cyc();
        chk("rst_irq", 8'(irq), 8'h0);
        chk("rst_pending", 8'(pending), 8'h0);
        chk("rst_err", 8'(timeout_err), 8'h0);
        rst_n = 1'b1;
        cyc();
        chk("rel_pending", 8'(pending), 8'hF);
        req_in = 4'h0; ack = 1'b1;
        repeat (20) cyc();
        chk("drain_pending", 8'(pending), 8'h0);
        ack = 1'b0;
        cyc();

        // 2: single source
        req_in = 4'b0100;
        cyc();
        chk("single_pend", 8'(pending), 8'h4);
        chk("single_irq0", 8'(irq), 8'h0);
        cyc();
        chk("single_irq", 8'(irq), 8'h1);
        chk("single_id", 8'(irq_id), 8'h2);
        ack = 1'b1; cyc(); ack = 1'b0;
        chk("single_done_irq", 8'(irq), 8'h0);
        chk("single_done_pend", 8'(pending), 8'h0);
        req_in = 4'h0;
        repeat (2) cyc();

        // 3: priority order 3,1,0 with two low cycles between services
        req_in = 4'b1011;
        cyc();
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk("prio_irq", 8'(irq), 8'h1);
            chk("prio_id", 8'(irq_id), (k == 0) ? 8'h3 : (k == 1) ? 8'h1 : 8'h0);
            ack = 1'b1; cyc(); ack = 1'b0;
            chk("prio_gap1", 8'(irq), 8'h0);
            cyc();
            chk("prio_gap2", 8'(irq), 8'h0);
            cyc();
        end
        chk("prio_pend", 8'(pending), 8'h0);
        req_in = 4'h0;
        repeat (2) cyc();

        // 4: masking holds source 3 pending until unmasked
        mask = 4'b1000; req_in = 4'b1001;
        cyc();
        cyc();
        chk("mask_id", 8'(irq_id), 8'h0);
        ack = 1'b1; cyc(); ack = 1'b0;
        repeat (3) cyc();
        chk("mask_hold_irq", 8'(irq), 8'h0);
        chk("mask_hold_pend", 8'(pending), 8'h8);
        mask = 4'h0;
        cyc();
        chk("unmask_irq", 8'(irq), 8'h1);
        chk("unmask_id", 8'(irq_id), 8'h3);
        ack = 1'b1; cyc(); ack = 1'b0;
        req_in = 4'h0;
        repeat (2) cyc();

        // 5: timeout retires after exactly TO cycles high
        req_in = 4'b0010;
        cyc();
        cyc();
        n = 0;
        for (int i = 0; i < 40 && irq; i++) begin
            n++;
            cyc();
        end
        chk("to_len", 8'(n), 8'(TO));
        chk("to_pend", 8'(pending[1]), 8'h0);
        chk("to_err", 8'(timeout_err), 8'h1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("to_clr", 8'(timeout_err), 8'h0);
        req_in = 4'h0;
        repeat (2) cyc();

        // 6: rise coinciding with ack keeps the source pending
        req_in = 4'b0100;
        cyc();
        cyc();
        chk("sw_id", 8'(irq_id), 8'h2);
        req_in = 4'b0000; cyc();
        req_in = 4'b0100; ack = 1'b1; cyc(); ack = 1'b0;
        chk("sw_pend", 8'(pending), 8'h4);
        chk("sw_irq0", 8'(irq), 8'h0);
        repeat (2) cyc();
        chk("sw_reissue", 8'(irq), 8'h1);
        chk("sw_reid", 8'(irq_id), 8'h2);
        ack = 1'b1; cyc(); ack = 1'b0;
        req_in = 4'h0;
        cyc();

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            req_in  = 4'($urandom);
            mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            ack     = ($urandom_range(0, 5) == 0);
            err_clr = ($urandom_range(0, 19) == 0);
            rst_n   = ($urandom_range(0, 199) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
